blockram_arb2: RTL and testbench

Two-port arbiter for the on-chip block RAM, which is mapped at 0x4000_0000–0x4000_FFFF. It shares the single pipeconnect slave port between two masters, e.g. instruction fetch (m0) and data/DMA (m1). Arbitration is round-robin or fixed-priority. Held transactions are locked to their owner, and one-cycle read data is routed back to the master that issued the read. It sits between the masters' `REQ/`RES buses and the `blockram` request port and adds no latency.

---
 rtl/blockram_arb2_pkg.sv | 36 +++
 rtl/blockram_arb2.sv | 128 ++++++++++++
 tb/tb_blockram_arb2.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/blockram_arb2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : blockram_arb2_pkg
// Description : Bus field layout and FSM state encoding for blockram_arb2.
// Revision    : 1.0 - initial release
// ============================================================================
package blockram_arb2_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int WBE_W  = 4;
    localparam int REQ_W  = ADDR_W + 2 + DATA_W + WBE_W;
    localparam int RES_W  = 1 + DATA_W;

    // Packed layout of the flattened request/response buses, MSB first.
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic              r;
        logic              w;
        logic [DATA_W-1:0] wd;
        logic [WBE_W-1:0]  wbe;
    } req_t;

    typedef struct packed {
        logic              hold;
        logic [DATA_W-1:0] rd;
    } res_t;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/blockram_arb2.sv
`default_nettype none
// ============================================================================
// Module      : blockram_arb2
// Description : Two-master arbiter in front of the block RAM request port.
// Revision    : 1.0 - initial release
// ============================================================================
module blockram_arb2
    import blockram_arb2_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REQ_W-1:0] i_m0_req,
    output logic [RES_W-1:0] o_m0_res,
    input  logic [REQ_W-1:0] i_m1_req,
    output logic [RES_W-1:0] o_m1_res,
    output logic [REQ_W-1:0] o_s_req,
    input  logic [RES_W-1:0] i_s_res
);

    req_t   w_m0;
    req_t   w_m1;
    req_t   w_win_req;
    res_t   w_s;
    res_t   w_m0_res;
    res_t   w_m1_res;
    logic   w_act0;
    logic   w_act1;
    logic   w_win;
    logic   w_win_act;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_last;
    logic   w_last_nxt;
    logic   r_rd_v;
    logic   w_rd_v_nxt;
    logic   r_rd_own;
    logic   w_rd_own_nxt;

    assign w_m0   = i_m0_req;
    assign w_m1   = i_m1_req;
    assign w_s    = i_s_res;
    assign w_act0 = w_m0.r | w_m0.w;
    assign w_act1 = w_m1.r | w_m1.w;

    // Free-arbitration pick: 0 = m0, 1 = m1. With nobody active m0 is
    // nominally picked but nothing is forwarded because it is inactive.
    function automatic logic f_pick(input logic act0, input logic act1,
                                    input logic last);
        if (act0 && act1)
            return ROUND_ROBIN ? ~last : 1'b0;
        return act1;
    endfunction

    always_comb begin
        w_win = 1'b0;
        case (r_state)
            LOCK0:   w_win = 1'b0;
            LOCK1:   w_win = 1'b1;
            default: w_win = f_pick(w_act0, w_act1, r_last);
        endcase
        w_win_act = w_win ? w_act1 : w_act0;
        w_win_req = w_win ? w_m1 : w_m0;
    end

    always_comb begin
        w_state_nxt  = ARB;
        w_last_nxt   = r_last;
        w_rd_v_nxt   = 1'b0;
        w_rd_own_nxt = r_rd_own;
        if (w_win_act) begin
            if (w_s.hold) begin
                w_state_nxt = w_win ? LOCK1 : LOCK0;
            end else begin
                w_last_nxt = w_win;
                if (w_win_req.r) begin
                    w_rd_v_nxt   = 1'b1;
                    w_rd_own_nxt = w_win;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ARB;
            r_last   <= 1'b1;
            r_rd_v   <= 1'b0;
            r_rd_own <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_last   <= w_last_nxt;
            r_rd_v   <= w_rd_v_nxt;
            r_rd_own <= w_rd_own_nxt;
        end
    end

    // Reset forces the outputs directly so masters stall while rst_n is low.
    always_comb begin
        o_s_req = '0;
        if (rst_n && w_win_act)
            o_s_req = w_win_req;

        w_m0_res.hold = 1'b1;
        w_m1_res.hold = 1'b1;
        if (rst_n) begin
            w_m0_res.hold = w_act0 & (w_win ? 1'b1 : w_s.hold);
            w_m1_res.hold = w_act1 & (w_win ? w_s.hold : 1'b1);
        end

        // Non-owners see zero data so the two responses stay OR-combinable.
        w_m0_res.rd = '0;
        w_m1_res.rd = '0;
        if (rst_n && r_rd_v) begin
            if (r_rd_own)
                w_m1_res.rd = w_s.rd;
            else
                w_m0_res.rd = w_s.rd;
        end
    end

    assign o_m0_res = w_m0_res;
    assign o_m1_res = w_m1_res;

endmodule
`default_nettype wire

// File: tb/tb_blockram_arb2.sv
`default_nettype none
// ============================================================================
// Module      : tb_blockram_arb2
// Description : Scoreboard bench for blockram_arb2 (round-robin and fixed).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blockram_arb2;
    import blockram_arb2_pkg::*;

    typedef struct {
        int          who;
        logic [31:0] d;
    } rd_exp_t;

    localparam logic [31:0] A10 = 32'h4000_0010;
    localparam logic [31:0] A20 = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_hold = 1'b0;
    req_t        m0q;
    req_t        m1q;
    req_t        s_req_a;
    req_t        s_req_b;
    res_t        s_res_a;
    res_t        s_res_b;
    res_t        m0_res_a;
    res_t        m1_res_a;
    res_t        m0_res_b;
    res_t        m1_res_b;
    logic [31:0] ram_rd;
    logic [31:0] mem    [0:63];
    logic [31:0] refmem [0:63];
    rd_exp_t     rdq[$];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    blockram_arb2 #(.ROUND_ROBIN(1'b1)) u_dut_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_m0_req (m0q),
        .o_m0_res (m0_res_a),
        .i_m1_req (m1q),
        .o_m1_res (m1_res_a),
        .o_s_req  (s_req_a),
        .i_s_res  (s_res_a)
    );

    blockram_arb2 #(.ROUND_ROBIN(1'b0)) u_dut_fp (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_m0_req (m0q),
        .o_m0_res (m0_res_b),
        .i_m1_req (m1q),
        .o_m1_res (m1_res_b),
        .o_s_req  (s_req_b),
        .i_s_res  (s_res_b)
    );

    assign s_res_a = {s_hold, ram_rd};
    assign s_res_b = {s_hold, 32'h0};

    // Block RAM model: one-cycle read latency, stalls while s_hold is high.
    always @(posedge clk) begin
        if ((s_req_a.r || s_req_a.w) && !s_hold) begin
            if (s_req_a.r)
                ram_rd <= mem[s_req_a.a[7:2]];
            if (s_req_a.w)
                for (int b = 0; b < 4; b++)
                    if (s_req_a.wbe[b])
                        mem[s_req_a.a[7:2]][8*b +: 8] = s_req_a.wd[8*b +: 8];
        end
    end

    function automatic req_t mk(input logic r, input logic w, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] wbe);
        req_t q;
        q.a   = a;
        q.r   = r;
        q.w   = w;
        q.wd  = wd;
        q.wbe = wbe;
        return q;
    endfunction

    task automatic chk(input string tag, input logic [REQ_W-1:0] got,
                       input logic [REQ_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic rst_chk();
        chk("rst_sreq",  s_req_a, '0);
        chk("rst_hold0", REQ_W'(m0_res_a.hold), REQ_W'(1'b1));
        chk("rst_hold1", REQ_W'(m1_res_a.hold), REQ_W'(1'b1));
        chk("rst_rd0",   REQ_W'(m0_res_a.rd), '0);
        chk("rst_rd1",   REQ_W'(m1_res_a.rd), '0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 rst_chk();
        #1 rst_n = 1'b1;
        rdq.delete();
    endtask

    // One bus cycle: ew = expected winner (-1 none), eh* = expected HOLDs.
    // sel 0 checks the round-robin instance incl. read data, sel 1 the fixed one.
    task automatic cyc(input int sel, input int ew, input logic eh0, input logic eh1);
        req_t        sq;
        req_t        exp_s;
        req_t        mq;
        res_t        r0;
        res_t        r1;
        rd_exp_t     e;
        logic [31:0] x0;
        logic [31:0] x1;
        @(negedge clk);
        if (sel == 0) begin
            sq = s_req_a; r0 = m0_res_a; r1 = m1_res_a;
        end else begin
            sq = s_req_b; r0 = m0_res_b; r1 = m1_res_b;
        end
        exp_s = (ew == 0) ? m0q : (ew == 1) ? m1q : '0;
        chk("s_req", sq, exp_s);
        chk("hold0", REQ_W'(r0.hold), REQ_W'(eh0));
        chk("hold1", REQ_W'(r1.hold), REQ_W'(eh1));
        if (sel == 0) begin
            x0 = '0;
            x1 = '0;
            if (rdq.size() > 0) begin
                e = rdq.pop_front();
                if (e.who == 0) x0 = e.d;
                else            x1 = e.d;
            end
            chk("rd0", REQ_W'(r0.rd), REQ_W'(x0));
            chk("rd1", REQ_W'(r1.rd), REQ_W'(x1));
            if (ew >= 0 && !s_hold) begin
                mq = (ew == 0) ? m0q : m1q;
                if (mq.r)
                    rdq.push_back('{ew, refmem[mq.a[7:2]]});
                if (mq.w)
                    for (int b = 0; b < 4; b++)
                        if (mq.wbe[b])
                            refmem[mq.a[7:2]][8*b +: 8] = mq.wd[8*b +: 8];
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        m0q = '0;
        m1q = '0;
        for (int i = 0; i < 64; i++) begin
            mem[i]    = 32'h1000_0000 + i;
            refmem[i] = 32'h1000_0000 + i;
        end
        mem[4]    = 32'hDEAD_BEEF;
        refmem[4] = 32'hDEAD_BEEF;
        mem[8]    = 32'hA5A5_0020;
        refmem[8] = 32'hA5A5_0020;

        // Single master read.
        do_reset();
        m0q = mk(1'b1, 1'b0, A10, 32'h0, 4'h0);
        cyc(0, 0, 1'b0, 1'b0);
        m0q = '0;
        cyc(0, -1, 1'b0, 1'b0);

        // Round-robin contention from reset.
        do_reset();
        m0q = mk(1'b1, 1'b0, A10, 32'h0, 4'h0);
        m1q = mk(1'b1, 1'b0, A20, 32'h0, 4'h0);
        for (int i = 0; i < 6; i++)
            cyc(0, i % 2, (i % 2) == 1, (i % 2) == 0);
        m0q = '0;
        m1q = '0;
        cyc(0, -1, 1'b0, 1'b0);

        // Fixed priority.
        do_reset();
        m0q = mk(1'b1, 1'b0, A10, 32'h0, 4'h0);
        m1q = mk(1'b1, 1'b0, A20, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++)
            cyc(1, 0, 1'b0, 1'b1);
        m0q = '0;
        cyc(1, 1, 1'b0, 1'b0);
        m1q = '0;
        cyc(1, -1, 1'b0, 1'b0);

        // Slave hold locks the grant to m1.
        do_reset();
        m1q = mk(1'b1, 1'b0, A20, 32'h0, 4'h0);
        s_hold = 1'b1;
        cyc(0, 1, 1'b0, 1'b1);
        m0q = mk(1'b1, 1'b0, A10, 32'h0, 4'h0);
        cyc(0, 1, 1'b1, 1'b1);
        cyc(0, 1, 1'b1, 1'b1);
        s_hold = 1'b0;
        cyc(0, 1, 1'b1, 1'b0);
        m1q = '0;
        cyc(0, 0, 1'b0, 1'b0);
        m0q = '0;
        cyc(0, -1, 1'b0, 1'b0);

        // Write then read across masters.
        do_reset();
        m0q = mk(1'b1, 1'b0, A20, 32'h0, 4'h0);
        m1q = mk(1'b0, 1'b1, A20, 32'h1234_5678, 4'hF);
        cyc(0, 0, 1'b0, 1'b1);
        m0q = '0;
        cyc(0, 1, 1'b0, 1'b0);
        m0q = mk(1'b1, 1'b0, A20, 32'h0, 4'h0);
        m1q = '0;
        cyc(0, 0, 1'b0, 1'b0);
        m0q = '0;
        cyc(0, -1, 1'b0, 1'b0);

        // Asynchronous reset while locked to m0.
        do_reset();
        m1q = mk(1'b1, 1'b0, A10, 32'h0, 4'h0);
        cyc(0, 1, 1'b0, 1'b0);
        m1q = '0;
        m0q = mk(1'b1, 1'b0, A20, 32'h0, 4'h0);
        s_hold = 1'b1;
        cyc(0, 0, 1'b1, 1'b0);
        #1 rst_n = 1'b0;
        #1 rst_chk();
        #1 rst_n = 1'b1;
        rdq.delete();
        s_hold = 1'b0;
        m1q = mk(1'b1, 1'b0, A10, 32'h0, 4'h0);
        cyc(0, 0, 1'b0, 1'b1);
        cyc(0, 1, 1'b1, 1'b0);
        m0q = '0;
        m1q = '0;
        cyc(0, -1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
